column_frame_loader: RTL

Configuration-path stage directly upstream of every tile ConfigMem in one fabric column. Accepts a 32-bit configuration word stream over a valid/ready handshake, assembles one full column frame (one word per row), and presents it as the column's FrameData. It then pulses exactly one FrameStrobe line so the tile frame latches capture it. Headers addressed to other columns are consumed silently, so one stream can be broadcast to all columns.

---
 rtl/col_cfg_pkg.sv | 26 ++
 rtl/frame_strobe_decoder.sv | 35 +++
 rtl/column_frame_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/col_cfg_pkg.sv
// Shared definitions for the column configuration loader: FSM state
// encoding, header magic and header field positions.
package col_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DISCARD,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hFA;

  // Least-significant bit of each 8-bit header field.
  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_COL_LSB   = 16;
  localparam int HDR_IDX_LSB   = 0;

  // Extract one 8-bit header field starting at bit lsb.
  function automatic logic [7:0] hdr_field(input logic [31:0] word, input int lsb);
    return 8'(word >> lsb);
  endfunction

endpackage

// File: rtl/frame_strobe_decoder.sv
// Frame-index to one-hot strobe decoder. in_range is combinational so the
// loader can validate a header index in the cycle it is accepted; the
// one-hot strobe itself is registered and clears asynchronously on reset.
module frame_strobe_decoder #(
  parameter int Width = 20
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [7:0]       idx,
  output logic             in_range,
  output logic [Width-1:0] strobe
);

  logic [Width-1:0] strobe_n;

  assign in_range = ({24'd0, idx} < 32'(Width));

  // Decode the index into a one-hot vector, all zero when disabled.
  always_comb begin
    // NOTE: every bit gets a default before the loop so no latch is inferred.
    strobe_n = '0;
    for (int i = 0; i < Width; i++) begin
      strobe_n[i] = en && ({24'd0, idx} == 32'(i));
    end
  end

  // Register the strobe so FrameStrobe is glitch-free at the tile latches.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) strobe <= '0;
    else     strobe <= strobe_n;
  end

endmodule

// File: rtl/column_frame_loader.sv
// Column frame loader: takes a header + NumberOfRows data words from a
// valid/ready stream, assembles the column frame and pulses one FrameStrobe
// line. Headers for other columns are swallowed so the stream can be
// broadcast. Optional feature: define FRAME_CHECKSUM_EN to require a
// trailing XOR checksum word after the data words of a matched frame.
module column_frame_loader
  import col_cfg_pkg::*;
#(
  parameter int         MaxFramesPerCol = 20,
  parameter int         FrameBitsPerRow = 32,
  parameter int         NumberOfRows    = 16,
  parameter logic [7:0] ColumnId        = 8'd0,
  parameter int         StrobeCycles    = 2
) (
  input  logic                                    CLK,
  input  logic                                    RST,
  input  logic [31:0]                             s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  input  logic                                    err_clr,
  output logic [NumberOfRows*FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic                                    busy,
  output logic                                    err
);

  localparam int FW = NumberOfRows * FrameBitsPerRow;
  localparam int CW = $clog2(NumberOfRows + 1);
  localparam int SW = $clog2(StrobeCycles + 1);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [CW-1:0] CSUM_SLOT    = CW'(NumberOfRows);
  localparam logic [CW-1:0] DISCARD_LAST = CSUM_SLOT;
`else
  localparam logic [CW-1:0] DATA_LAST    = CW'(NumberOfRows - 1);
  localparam logic [CW-1:0] DISCARD_LAST = DATA_LAST;
`endif
  localparam logic [SW-1:0] STROBE_LAST = SW'(StrobeCycles - 1);

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q;
  logic [SW-1:0] str_q;
  logic [7:0]    idx_q;
  logic [FW-1:0] frame_q;
  logic          ready_q, busy_q, err_q;
  logic          accept, cnt_clr, cnt_inc, do_shift, idx_load, err_set;
  logic          dec_en, in_range;
  logic [7:0]    dec_idx;
`ifdef FRAME_CHECKSUM_EN
  logic [31:0]   csum_q;
`endif

  assign accept      = s_valid && ready_q;
  assign s_ready     = ready_q;
  assign busy        = busy_q;
  assign err         = err_q;
  assign FrameData   = frame_q;

  // In IDLE the decoder range-checks the incoming header; later it decodes the latched index.
  assign dec_idx = (state_q == IDLE) ? hdr_field(s_data, HDR_IDX_LSB) : idx_q;
  assign dec_en  = (state_n == STROBE);

  frame_strobe_decoder #(
    .Width (MaxFramesPerCol)
  ) u_strobe_dec (
    .CLK      (CLK),
    .RST      (RST),
    .en       (dec_en),
    .idx      (dec_idx),
    .in_range (in_range),
    .strobe   (FrameStrobe)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_n  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    do_shift = 1'b0;
    idx_load = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        cnt_clr = 1'b1;
        if (hdr_field(s_data, HDR_MAGIC_LSB) != HDR_MAGIC) begin
          err_set = 1'b1;
        end else if (hdr_field(s_data, HDR_COL_LSB) != ColumnId) begin
          state_n = DISCARD;
        end else if (!in_range) begin
          err_set = 1'b1;
          state_n = DISCARD;
        end else begin
          idx_load = 1'b1;
          state_n  = LOAD;
        end
      end
      LOAD: if (accept) begin
        cnt_inc = 1'b1;
`ifdef FRAME_CHECKSUM_EN
        if (cnt_q == CSUM_SLOT) begin
          if (s_data != csum_q) begin
            err_set = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = SETUP;
          end
        end else begin
          do_shift = 1'b1;
        end
`else
        do_shift = 1'b1;
        if (cnt_q == DATA_LAST) state_n = SETUP;
`endif
      end
      DISCARD: if (accept) begin
        cnt_inc = 1'b1;
        if (cnt_q == DISCARD_LAST) state_n = IDLE;
      end
      SETUP:   state_n = STROBE;
      STROBE:  if (str_q == STROBE_LAST) state_n = HOLD;
      HOLD:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_n;
  end

  // Word/strobe counters, latched index and registered status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q   <= '0;
      str_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (cnt_clr)      cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 1'b1;
      str_q <= (state_q == STROBE) ? str_q + 1'b1 : '0;
      if (idx_load) idx_q <= hdr_field(s_data, HDR_IDX_LSB);
      ready_q <= (state_n == IDLE) || (state_n == LOAD) || (state_n == DISCARD);
      busy_q  <= (state_n != IDLE);
      if (err_set)      err_q <= 1'b1;
      else if (err_clr) err_q <= 1'b0;
    end
  end

  // Frame shift register: new words enter at row 0 and age towards the top row.
  always_ff @(posedge CLK or posedge RST) begin
    // NOTE: this wide register is reset on purpose; the tile latches must see all-zero FrameData after reset.
    if (RST)           frame_q <= '0;
    else if (do_shift) frame_q <= (frame_q << FrameBitsPerRow) | FW'(s_data);
  end

`ifdef FRAME_CHECKSUM_EN
  // Running XOR of the data words of the frame being loaded.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)           csum_q <= '0;
    else if (cnt_clr)  csum_q <= '0;
    else if (do_shift) csum_q <= csum_q ^ s_data;
  end
`endif

endmodule
